// File: rtl/ram2_arbiter.sv
// rtl/ram2_arbiter.sv - RAM2 arbiter between instruction fetch and MEM-stage data access (option: RAM2_ARB_WPROTECT_EN)
module ram2_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [17:0] mem_addr_i,
    input  logic [15:0] mem_wdata_i,
    output logic [15:0] mem_rdata_o,
    output logic        mem_done_o,
    input  logic [15:0] if_pc_i,
    output logic [15:0] if_inst_o,
    output logic        if_valid_o,
    output logic        if_stall_o,
    output logic        is_RAM2_mem_o,
    output logic        isread_mem_o,
    output logic        iswrite_mem_o,
    output logic [17:0] addr_mem_o,
    output logic [15:0] data_mem_o,
    output logic [15:0] addr_if_o,
    input  logic [15:0] ram2res_i
);

    localparam logic [15:0] NOP_INST = 16'h0800;

    typedef enum logic {
        FETCH = 1'b0,
        MEM   = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] mem_rdata_q, mem_rdata_d;
    logic        mem_done_q, mem_done_d;
    logic [15:0] if_inst_q, if_inst_d;
    logic        if_valid_q, if_valid_d;
    logic [17:0] lat_addr_q, lat_addr_d;
    logic [15:0] lat_wdata_q, lat_wdata_d;
    logic        lat_we_q, lat_we_d;
    logic        accept;
    logic        wr_blocked;

    // A request still high during its own done cycle must not be re-accepted.
    assign accept = (state_q == FETCH) && mem_req_i && !mem_done_q;

`ifdef RAM2_ARB_WPROTECT_EN
    // Writes into the lowest 16K words (program area) are suppressed on the bus.
    assign wr_blocked = lat_we_q && (lat_addr_q[17:14] == 4'h0);
`else
    assign wr_blocked = 1'b0;
`endif

    // Next-state and next-output computation for the fetch/mem FSM.
    always_comb begin
        state_d     = state_q;
        mem_rdata_d = mem_rdata_q;
        mem_done_d  = 1'b0;
        if_inst_d   = if_inst_q;
        if_valid_d  = if_valid_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        lat_we_d    = lat_we_q;
        case (state_q)
            FETCH: begin
                if_inst_d  = ram2res_i;
                if_valid_d = 1'b1;
                if (accept) begin
                    lat_addr_d  = mem_addr_i;
                    lat_wdata_d = mem_wdata_i;
                    lat_we_d    = mem_we_i;
                    if_valid_d  = 1'b0;
                    state_d     = MEM;
                end
            end
            MEM: begin
                if_valid_d = 1'b0;
                mem_done_d = 1'b1;
                state_d    = FETCH;
                if (!lat_we_q) begin
                    mem_rdata_d = ram2res_i;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // State and registered outputs; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH;
            mem_rdata_q <= 16'h0000;
            mem_done_q  <= 1'b0;
            if_inst_q   <= NOP_INST;
            if_valid_q  <= 1'b0;
            lat_addr_q  <= 18'h0;
            lat_wdata_q <= 16'h0;
            lat_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_rdata_q <= mem_rdata_d;
            mem_done_q  <= mem_done_d;
            if_inst_q   <= if_inst_d;
            if_valid_q  <= if_valid_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            lat_we_q    <= lat_we_d;
        end
    end

    // Bus strobes come only from state decode and latched request fields.
    always_comb begin
        is_RAM2_mem_o = (state_q == MEM);
        iswrite_mem_o = (state_q == MEM) && lat_we_q && !wr_blocked;
        isread_mem_o  = (state_q == MEM) && !lat_we_q;
        if_stall_o    = (state_q == MEM) || accept;
    end

    assign addr_mem_o  = lat_addr_q;
    assign data_mem_o  = lat_wdata_q;
    assign addr_if_o   = if_pc_i;
    assign mem_rdata_o = mem_rdata_q;
    assign mem_done_o  = mem_done_q;
    assign if_inst_o   = if_inst_q;
    assign if_valid_o  = if_valid_q;

endmodule

// File: tb/tb_ram2_arbiter.sv
// tb/tb_ram2_arbiter.sv - directed self-checking bench for ram2_arbiter
module tb_ram2_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [17:0] mem_addr_i;
    logic [15:0] mem_wdata_i;
    logic [15:0] mem_rdata_o;
    logic        mem_done_o;
    logic [15:0] if_pc_i;
    logic [15:0] if_inst_o;
    logic        if_valid_o;
    logic        if_stall_o;
    logic        is_RAM2_mem_o;
    logic        isread_mem_o;
    logic        iswrite_mem_o;
    logic [17:0] addr_mem_o;
    logic [15:0] data_mem_o;
    logic [15:0] addr_if_o;
    logic [15:0] ram2res_i;

    int vectors = 0;
    int errors  = 0;
    logic [15:0] exp_q[$];

    ram2_arbiter dut (
        .clk(clk), .rst(rst),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
        .if_pc_i(if_pc_i), .if_inst_o(if_inst_o), .if_valid_o(if_valid_o),
        .if_stall_o(if_stall_o), .is_RAM2_mem_o(is_RAM2_mem_o),
        .isread_mem_o(isread_mem_o), .iswrite_mem_o(iswrite_mem_o),
        .addr_mem_o(addr_mem_o), .data_mem_o(data_mem_o), .addr_if_o(addr_if_o),
        .ram2res_i(ram2res_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for mem_done_o, then pop the scoreboard and compare read data.
    task automatic wait_done(input string tag, input int budget);
        int seen;
        logic [15:0] e;
        seen = 0;
        for (int i = 0; i < budget && seen == 0; i++) begin
            @(negedge clk);
            if (mem_done_o) seen = 1;
        end
        check({tag, "_done_seen"}, seen, 1);
        if (seen != 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_rdata"}, mem_rdata_o, e);
        end
    endtask

    initial begin
        int          wr_cycles;
        logic [5:0]  mem_seq;
        logic [5:0]  done_seq;
        logic [15:0] e;

        rst = 1'b1; mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0;
        mem_wdata_i = '0; if_pc_i = '0; ram2res_i = '0;
        @(negedge clk); @(negedge clk);
        check("rst_rdata", mem_rdata_o, 16'h0000);
        check("rst_done", mem_done_o, 0);
        check("rst_inst", if_inst_o, 16'h0800);
        check("rst_valid", if_valid_o, 0);
        check("rst_isram2", is_RAM2_mem_o, 0);
        check("rst_iswrite", iswrite_mem_o, 0);

        // Fetch
        rst = 1'b0; if_pc_i = 16'h0010; ram2res_i = 16'h6801;
        @(negedge clk);
        check("fetch_inst", if_inst_o, 16'h6801);
        check("fetch_valid", if_valid_o, 1);
        check("fetch_addr_if", addr_if_o, 16'h0010);
        check("fetch_stall", if_stall_o, 0);

        // Read
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 18'h08000; ram2res_i = 16'hBEEF;
        exp_q.push_back(16'hBEEF);
        #1 check("rd_stall_now", if_stall_o, 1);
        @(negedge clk);
        check("rd_isram2", is_RAM2_mem_o, 1);
        check("rd_isread", isread_mem_o, 1);
        check("rd_iswrite", iswrite_mem_o, 0);
        check("rd_addr", addr_mem_o, 18'h08000);
        check("rd_valid_mem", if_valid_o, 0);
        check("rd_stall_mem", if_stall_o, 1);
        check("rd_done_early", mem_done_o, 0);
        wait_done("rd", 4);
        check("rd_valid_done", if_valid_o, 0);
        mem_req_i = 1'b0;
        @(negedge clk);
        check("rd_done_one", mem_done_o, 0);
        check("rd_valid_back", if_valid_o, 1);

        // Write: rdata must not change even though the bus shows other data
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 18'h08004; mem_wdata_i = 16'h1234;
        ram2res_i = 16'h5555;
        exp_q.push_back(16'hBEEF);
        wr_cycles = 0;
        for (int i = 0; i < 4 && !mem_done_o; i++) begin
            @(negedge clk);
            if (iswrite_mem_o) begin
                wr_cycles++;
                check("wr_data", data_mem_o, 16'h1234);
                check("wr_addr", addr_mem_o, 18'h08004);
                check("wr_isread", isread_mem_o, 0);
            end
        end
        check("wr_done_seen", mem_done_o, 1);
        check("wr_strobe_cycles", wr_cycles, 1);
        if (mem_done_o && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wr_rdata_kept", mem_rdata_o, e);
        end
        mem_req_i = 1'b0; mem_we_i = 1'b0;
        @(negedge clk);

        // Back-to-back reads with request held high
        mem_req_i = 1'b1; mem_addr_i = 18'h0A000; ram2res_i = 16'h1111;
        exp_q.push_back(16'h1111);
        exp_q.push_back(16'h2222);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            mem_seq[i]  = is_RAM2_mem_o;
            done_seq[i] = mem_done_o;
            if (mem_done_o && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("b2b_rdata", mem_rdata_o, e);
            end
            if (i == 2) ram2res_i = 16'h2222;
            if (i == 5) mem_req_i = 1'b0;
        end
        check("b2b_mem_seq", mem_seq, 6'b001001);
        check("b2b_done_seq", done_seq, 6'b010010);
        check("b2b_queue_empty", exp_q.size(), 0);
        @(negedge clk);

        // Reset asserted during a write MEM cycle
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 18'h0C000; mem_wdata_i = 16'hABCD;
        @(negedge clk);
        check("rstmid_in_mem", iswrite_mem_o, 1);
        rst = 1'b1;
        #1;
        check("rstmid_isram2", is_RAM2_mem_o, 0);
        check("rstmid_iswrite", iswrite_mem_o, 0);
        check("rstmid_inst", if_inst_o, 16'h0800);
        check("rstmid_rdata", mem_rdata_o, 16'h0000);
        mem_req_i = 1'b0; mem_we_i = 1'b0;
        @(negedge clk);
        check("rstmid_nodone", mem_done_o, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_nodone2", mem_done_o, 0);

        // Low-address write (protected region when option is built in)
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 18'h00100; mem_wdata_i = 16'h7777;
        @(negedge clk);
        check("prot_isram2", is_RAM2_mem_o, 1);
        check("prot_isread", isread_mem_o, 0);
`ifdef RAM2_ARB_WPROTECT_EN
        check("prot_iswrite", iswrite_mem_o, 0);
`else
        check("prot_iswrite", iswrite_mem_o, 1);
`endif
        exp_q.push_back(16'h0000);
        wait_done("prot", 4);
        mem_req_i = 1'b0; mem_we_i = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
